// File: rtl/dma_axi_slave_mem.sv
// AXI3 slave RAM used as the DMA target endpoint. Independent write (AW/W/B) and
// read (AR/R) FSMs, one outstanding INCR burst each, byte-lane RAM slices.

module dma_axi_slave_mem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wbyte,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rbyte
);
  logic [7:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) ram[widx] <= wbyte;
  end

  assign rbyte = ram[ridx];
endmodule

module dma_axi_slave_mem #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] MEM_BASE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_W-1:0]       wid,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);
  localparam int              BYTES     = DATA_W / 8;
  localparam int              OFF_W     = $clog2(BYTES);
  localparam int              IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_WORDS * BYTES);
  localparam logic [2:0]      SIZE_MAX  = 3'(OFF_W);
  localparam logic [1:0]      OKAY      = 2'b00;
  localparam logic [1:0]      SLVERR    = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // One extra bit so addresses below MEM_BASE wrap high and fail the range test.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} - {1'b0, MEM_BASE}) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - MEM_BASE) >> OFF_W);
  endfunction

  function automatic logic [ADDR_W-1:0] step(input logic [2:0] s);
    return ADDR_W'(1) << s;
  endfunction

  // ---------------- write channel ----------------
  wstate_t          w_state, w_next;
  burst_t           wb;
  logic [3:0]       wbeat;
  logic             werr;
  logic             aw_hs, w_hs, b_hs;
  logic             w_last_beat, w_beat_ok, w_beat_err;
  logic [IDX_W-1:0] w_idx;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bvalid & bready;
  assign w_last_beat = (wbeat == wb.len);
  assign w_beat_ok   = addr_ok(wb.addr) && (wb.size <= SIZE_MAX);
  assign w_beat_err  = (wid != bid) || (wlast != w_last_beat) || !w_beat_ok;
  assign w_idx       = word_idx(wb.addr);

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // bid doubles as the latched AW ID; it is only observed while bvalid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= OKAY;
      wb      <= '0;
      wbeat   <= '0;
      werr    <= 1'b0;
    end else begin
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        wb    <= '{addr: awaddr, len: awlen, size: awsize};
        bid   <= awid;
        wbeat <= '0;
        werr  <= 1'b0;
      end
      if (w_hs) begin
        wb.addr <= wb.addr + step(wb.size);
        wbeat   <= wbeat + 4'd1;
        werr    <= werr | w_beat_err;
        if (w_last_beat) bresp <= (werr | w_beat_err) ? SLVERR : OKAY;
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_state, r_next;
  burst_t                rb;
  logic [3:0]            rbeat, rbeat_nx;
  logic                  ar_hs, r_hs, r_last_beat, rd_ok;
  logic [ADDR_W-1:0]     rd_addr;
  logic [2:0]            rd_size;
  logic [IDX_W-1:0]      r_idx;
  logic [BYTES-1:0][7:0] lane_rd;

  assign ar_hs       = arvalid & arready;
  assign r_hs        = rvalid & rready;
  assign r_last_beat = (rbeat == rb.len);
  assign rbeat_nx    = rbeat + 4'd1;

  // The RAM is looked up for the beat that will be presented after this edge:
  // beat 0 straight from AR, later beats from the advanced burst address.
  assign rd_addr = (r_state == R_IDLE) ? araddr : rb.addr + step(rb.size);
  assign rd_size = (r_state == R_IDLE) ? arsize : rb.size;
  assign rd_ok   = addr_ok(rd_addr) && (rd_size <= SIZE_MAX);
  assign r_idx   = word_idx(rd_addr);

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
      rb      <= '0;
      rbeat   <= '0;
    end else begin
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        rb    <= '{addr: araddr, len: arlen, size: arsize};
        rbeat <= '0;
        rid   <= arid;
        rlast <= (arlen == 4'd0);
        rdata <= rd_ok ? lane_rd : '0;
        rresp <= rd_ok ? OKAY : SLVERR;
      end else if (r_hs && !r_last_beat) begin
        rb.addr <= rd_addr;
        rbeat   <= rbeat_nx;
        rlast   <= (rbeat_nx == rb.len);
        rdata   <= rd_ok ? lane_rd : '0;
        rresp   <= rd_ok ? OKAY : SLVERR;
      end
    end
  end

  // ---------------- byte-lane RAM ----------------
  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    dma_axi_slave_mem_lane #(.DEPTH(MEM_WORDS), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (w_hs && w_beat_ok && wstrb[g]),
      .widx  (w_idx),
      .wbyte (wdata[8*g +: 8]),
      .ridx  (r_idx),
      .rbyte (lane_rd[g])
    );
  end
endmodule

// File: tb/tb_dma_axi_slave_mem.sv
// Scoreboard bench for dma_axi_slave_mem: a word model predicts B and R responses
// as stimulus is driven; the DUT's responses are popped and compared as they appear.
module tb_dma_axi_slave_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, wid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  dma_axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model [1024];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit in_rng(input logic [31:0] a, input logic [2:0] s);
    return (a < 32'h1000) && (s <= 3'd2);
  endfunction

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wdat[i] = base + 32'(i);
      wstb[i] = 4'hF;
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [3:0] data_id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input int wlast_beat,
                           input int b_delay);
    logic [31:0] a;
    logic        err;
    bexp_t       e;
    int          n;
    err = (data_id != id);
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      err = err | !in_rng(a, size) | ((b == wlast_beat) != (b == int'(len)));
      a = a + (32'd1 << size);
    end
    bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin
      vectors++; miscompares++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
      awvalid = 1'b0; bq.delete(); return;
    end
    @(negedge clk);
    awvalid = 1'b0;
    vectors++;
    if (awready !== 1'b0 || wready !== 1'b1) begin
      miscompares++;
      $display("FAIL aw_to_w: awready=%b wready=%b required 0 1", awready, wready);
    end
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wid = data_id; wdata = wdat[b]; wstrb = wstb[b]; wlast = (b == wlast_beat);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin
        vectors++; miscompares++;
        $display("FAIL w_timeout: beat %0d wready=%b required 1", b, wready);
        wvalid = 1'b0; wlast = 1'b0; bq.delete(); return;
      end
      if (in_rng(a, size))
        for (int i = 0; i < 4; i++)
          if (wstb[b][i]) model[a[11:2]][8*i +: 8] = wdat[b][8*i +: 8];
      a = a + (32'd1 << size);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    vectors++;
    if (bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL b_latency: bvalid=%b required 1", bvalid);
    end
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    e = bq[0];
    for (int d = 0; d < b_delay; d++) begin
      vectors++;
      if (bvalid !== 1'b1 || bid !== e.id || bresp !== e.resp) begin
        miscompares++;
        $display("FAIL b_hold: bvalid=%b bid=%0h bresp=%b required 1 %0h %b", bvalid, bid, bresp, e.id, e.resp);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    vectors++;
    if (bvalid !== 1'b1 || bid !== e.id || bresp !== e.resp) begin
      miscompares++;
      $display("FAIL bresp: bvalid=%b bid=%0h bresp=%b required 1 %0h %b", bvalid, bid, bresp, e.id, e.resp);
    end
    @(negedge clk);
    bready = 1'b0;
    void'(bq.pop_front());
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      miscompares++;
      $display("FAIL b_to_aw: bvalid=%b awready=%b required 0 1", bvalid, awready);
    end
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input bit toggle);
    logic [31:0] a;
    rexp_t       e;
    int          n;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      rq.push_back('{id: id, data: in_rng(a, size) ? model[a[11:2]] : 32'h0,
                     resp: in_rng(a, size) ? 2'b00 : 2'b10, last: (b == int'(len))});
      a = a + (32'd1 << size);
    end
    @(negedge clk);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin
      vectors++; miscompares++;
      $display("FAIL ar_timeout: arready=%b required 1", arready);
      arvalid = 1'b0; rq.delete(); return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1 || arready !== 1'b0) begin
      miscompares++;
      $display("FAIL r_first: rvalid=%b arready=%b required 1 0", rvalid, arready);
    end
    n = 0;
    while (rq.size() > 0 && n < 200) begin
      rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid) begin
        e = rq[0];
        vectors++;
        if (rid !== e.id || rdata !== e.data || rresp !== e.resp || rlast !== e.last) begin
          miscompares++;
          $display("FAIL rbeat @%0h: rid=%0h rdata=%08h rresp=%b rlast=%b required %0h %08h %b %b",
                   addr, rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
        end
        if (rready) void'(rq.pop_front());
      end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    vectors++;
    if (rq.size() != 0) begin
      miscompares++;
      $display("FAIL r_timeout: %0d beats outstanding required 0", rq.size());
      rq.delete();
    end else if (rvalid !== 1'b0 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_to_ar: rvalid=%b arready=%b required 0 1", rvalid, arready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid, bid, bresp, arready, rid, rdata, rresp, rlast, rvalid} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: awready=%b arready=%b wready=%b bvalid=%b rvalid=%b rdata=%08h required all 0",
               awready, arready, wready, bvalid, rvalid, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: awready=%b arready=%b wready=%b required 1 1 0", awready, arready, wready);
    end
  endtask

  task automatic test_single;
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    axi_write(4'd3, 4'd3, 32'h10, 4'd0, 3'd2, 0, 0);
    axi_read(4'd3, 32'h10, 4'd0, 3'd2, 1'b0);
  endtask

  task automatic test_burst_backpressure;
    fill(32'h0, 8);
    axi_write(4'd1, 4'd1, 32'h100, 4'd7, 3'd2, 7, 5);
    axi_read(4'd2, 32'h100, 4'd7, 3'd2, 1'b1);
  endtask

  task automatic test_strobes;
    fill(32'h0, 1);
    axi_write(4'd1, 4'd1, 32'h0, 4'd0, 3'd2, 0, 0);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    axi_write(4'd1, 4'd1, 32'h0, 4'd0, 3'd2, 0, 0);
    axi_read(4'd1, 32'h0, 4'd0, 3'd2, 1'b0);
  endtask

  task automatic test_narrow;
    fill(32'h0, 1);
    axi_write(4'd4, 4'd4, 32'h20, 4'd0, 3'd2, 0, 0);
    for (int b = 0; b < 4; b++) begin
      wdat[b] = {4{8'(8'h10 + b)}};
      wstb[b] = 4'(1 << b);
    end
    axi_write(4'd4, 4'd4, 32'h20, 4'd3, 3'd0, 3, 0);
    axi_read(4'd4, 32'h20, 4'd0, 3'd2, 1'b0);
    axi_read(4'd5, 32'h20, 4'd3, 3'd0, 1'b0);
  endtask

  task automatic test_errors;
    wdat[0] = 32'hA5A5A5A5; wdat[1] = 32'h5A5A5A5A; wstb[0] = 4'hF; wstb[1] = 4'hF;
    axi_write(4'd1, 4'd1, 32'h0, 4'd1, 3'd2, 1, 0);
    fill(32'hC0DE0000, 4);
    axi_write(4'd7, 4'd7, 32'hFF8, 4'd3, 3'd2, 3, 0);
    axi_read(4'd1, 32'h0, 4'd1, 3'd2, 1'b0);
    axi_read(4'd2, 32'hFF8, 4'd3, 3'd2, 1'b0);
    fill(32'h30, 4);
    axi_write(4'd2, 4'd2, 32'h300, 4'd3, 3'd2, 2, 0);
    axi_read(4'd2, 32'h300, 4'd3, 3'd2, 1'b0);
    fill(32'h340, 1);
    axi_write(4'd6, 4'd7, 32'h340, 4'd0, 3'd2, 0, 0);
    fill(32'hBAD0BAD0, 1);
    axi_write(4'd6, 4'd6, 32'h340, 4'd0, 3'd3, 0, 0);
    axi_read(4'd6, 32'h340, 4'd0, 3'd2, 1'b0);
    axi_read(4'd6, 32'h340, 4'd0, 3'd3, 1'b0);
  endtask

  task automatic test_concurrent;
    fill(32'h0100, 4);
    axi_write(4'd1, 4'd1, 32'h200, 4'd3, 3'd2, 3, 0);
    fill(32'h0200, 4);
    fork
      axi_write(4'd2, 4'd2, 32'h200, 4'd3, 3'd2, 3, 0);
      axi_read(4'd3, 32'h200, 4'd3, 3'd2, 1'b0);
    join
    axi_read(4'd3, 32'h200, 4'd3, 3'd2, 1'b0);
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    arvalid = 1'b1; arid = 4'd9; araddr = 32'h100; arlen = 4'd7; arsize = 3'd2; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || awready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: rvalid=%b arready=%b awready=%b required 0 0 0", rvalid, arready, awready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rready = 1'b0;
    vectors++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
    end
    axi_read(4'd1, 32'h100, 4'd1, 3'd2, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst_backpressure();
    test_strobes();
    test_narrow();
    test_errors();
    test_concurrent();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dma_axi_slave_mem.md
# dma_axi_slave_mem

Synthesizable AXI3 slave memory that answers the DMA master on the same AXI channel set the DMA drives: AW/W/B for writes, AR/R for reads. It serves as the target endpoint in block-level and top-level DMA environments. It holds a word-addressed RAM. Writes and reads are handled by independent state machines, each allowing one outstanding burst, with INCR bursts only.

## Interface
Parameters:
- ID_W, 4, width of awid/wid/bid/arid/rid
- ADDR_W, 32, address width
- DATA_W, 32, data width (power of 2, ≥ 8); strobe width is DATA_W/8
- MEM_WORDS, 1024, RAM depth in DATA_W words
- MEM_BASE, 0, byte address of word 0; must be DATA_W/8-aligned

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- awid  in  ID_W  write address ID
- awaddr  in  ADDR_W  write start byte address
- awlen  in  4  beats-1
- awsize  in  3  log2 bytes per beat
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wid  in  ID_W  write data ID
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes
- wlast  in  1  last write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  response ID
- bresp  out  2  response; OKAY=2'b00, SLVERR=2'b10
- bvalid  out  1  B valid
- bready  in  1  B ready
- arid  in  ID_W  read address ID
- araddr  in  ADDR_W  read start byte address
- arlen  in  4  beats-1
- arsize  in  3  log2 bytes per beat
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_W  read ID
- rdata  out  DATA_W  read data
- rresp  out  2  per-beat response
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready

## Operation
**Write FSM** (W_IDLE, W_DATA, W_RESP):
- W_IDLE
  - awready=1.
  - On awvalid&&awready, latch awid/awaddr/awlen/awsize, clear the beat counter and error flag, and go to W_DATA.
- W_DATA
  - wready=1.
  - Each wvalid&&wready beat writes the lanes enabled by wstrb into mem[(addr-MEM_BASE)>>log2(DATA_W/8)].
  - After each beat, addr += 2^size, beat counter +1.
- Write error flag: set to SLVERR if any of the following holds.
  - wid != latched awid.
  - wlast != (beat == len).
  - The beat address falls outside [MEM_BASE, MEM_BASE+MEM_WORDS*DATA_W/8).
  - size > log2(DATA_W/8).
- Beats that are out of range or oversize are not written.
- The burst ends on beat len+1, regardless of wlast. The FSM then goes to W_RESP.
- W_RESP
  - bvalid=1, bid=latched ID, bresp=flag.
  - Hold until bready, then return to W_IDLE.

**Read FSM** (R_IDLE, R_DATA):
- R_IDLE
  - arready=1.
  - On arvalid&&arready, latch the AR fields and go to R_DATA.
- R_DATA
  - rvalid=1, rid=latched ID, rlast=(beat==len).
  - rdata = mem word at the current address; rresp=OKAY.
  - Out-of-range or oversize beats return rdata=0 with rresp=SLVERR.
  - On rvalid&&rready, advance address and beat. After the last beat, return to R_IDLE.
- Address wrap: no 4 KB boundary check; the address increments linearly.

## Timing
- Reset values (asynchronous): every output is 0, including awready and arready. FSMs go to IDLE.
  - awready and arready go to 1 on the first clk edge after rst deasserts.
  - RAM contents are not reset.
- All outputs are registered; no combinational input-to-output paths.
- Write path:
  - awready drops the cycle after the AW handshake; wready rises that same cycle.
  - bvalid rises the cycle after the last W handshake.
  - awready rises the cycle after the B handshake.
- Read path:
  - rvalid with beat 0 rises the cycle after the AR handshake.
  - Back-to-back beats stream at 1 beat per cycle while rready=1.
  - rdata, rresp, and rlast are held stable while rvalid&&!rready.
  - arready rises the cycle after the last R handshake.
- Throughput: minimum issue interval is len+3 cycles per write burst and len+2 cycles per read burst.
- Channel independence: read and write bursts proceed concurrently.
  - A read beat and a write beat to the same word in the same cycle: the read returns old data.
  - Newly written data is visible to reads sampled on any later edge.
- AW, AR, and W inputs are ignored while the corresponding ready is 0.
- Reset mid-burst: the burst is aborted and no B or R response is produced. Beats already written remain in the RAM.

## Test plan
- **Single write:** AW id=3, addr=0x10, len=0, size=2, then W 0xDEADBEEF, strb=4'hF, wlast=1 -> B id=3, bresp=00 the cycle after the W handshake; AR read of 0x10 -> rdata=0xDEADBEEF, rlast=1, rresp=00.
- **Burst with backpressure:** write len=7 at 0x100 with data 0..7, with bready held low for 5 cycles -> bvalid stays high, bresp=00. Read the same range with rready toggling -> 8 beats 0..7, rlast only on beat 7, rdata stable during stalls.
- **Strobes and narrow transfers:**
  - Write 0xAABBCCDD with strb=4'b0101 over 0x0 -> read returns 0x00BB00DD.
  - size=0, len=3 at 0x20 -> address advances by 1 per beat.
- **Errors:**
  - Burst that crosses the top of RAM -> SLVERR on B, and no write outside the RAM.
  - wlast asserted early at beat 2 of len=3 -> 4 beats are still accepted, bresp=10.
  - Read past the end -> those beats return rdata=0, rresp=10.
- **Concurrency and reset:**
  - Overlapping read and write bursts to the same words -> same-cycle collisions return old data.
  - rst asserted mid read burst -> rvalid=0 immediately, arready=1 one edge after release.
